// File: rtl/dfu_flash_sequencer.sv
// dfu_flash_sequencer: sits between the DFU class logic and the SPI flash bridge.
// A DNLOAD block is collected into a page buffer and then replayed into the
// bridge page-write port. An UPLOAD block is streamed from the bridge read port
// through a 4-entry FIFO. DFU block numbers map linearly onto flash pages.
module dfu_flash_sequencer #(
    parameter int unsigned PAGE_SIZE = 32'd256,
    parameter logic [15:0] BASE_PAGE = 16'h0000,
    parameter logic [15:0] MAX_PAGES = 16'h0400
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dn_start,
    input  logic        up_start,
    input  logic [15:0] dfu_block,
    input  logic [15:0] dfu_length,
    input  logic        dn_valid,
    output logic        dn_ready,
    input  logic [7:0]  dn_data,
    output logic        up_valid,
    input  logic        up_ready,
    output logic [7:0]  up_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] flash_address,
    output logic        flash_rd_request,
    output logic        flash_rd_data_free,
    input  logic        flash_rd_data_put,
    input  logic [7:0]  flash_rd_data,
    output logic        flash_wr_request,
    output logic        flash_wr_data_avail,
    input  logic        flash_wr_busy,
    input  logic        flash_wr_data_get,
    output logic [7:0]  flash_wr_data
);
    // CW holds 0..PAGE_SIZE, AW indexes the page buffer
    localparam int CW = $clog2(PAGE_SIZE + 32'd1);
    localparam int AW = $clog2(PAGE_SIZE);
    localparam logic [15:0]   PAGE_SIZE_W = 16'(PAGE_SIZE);
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DN_FILL   = 3'd1,
        ST_DN_REQ    = 3'd2,
        ST_DN_STREAM = 3'd3,
        ST_DN_WAIT   = 3'd4,
        ST_UP_STREAM = 3'd5,
        ST_UP_DRAIN  = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [CW-1:0]   len_r;
    logic [CW-1:0]   wptr_r;
    logic [CW-1:0]   rptr_r;      // write replay pointer, or bytes received on upload
    logic [15:0]     addr_r;
    logic            error_r;
    logic            done_r;
    logic [7:0]      wr_data_r;
    logic [7:0]      buf_mem_r [PAGE_SIZE];
    logic [7:0]      fifo_mem_r [4];
    logic [1:0]      fifo_wp_r;
    logic [1:0]      fifo_rp_r;
    logic [2:0]      fifo_cnt_r;

    logic            start_s;
    logic            bad_s;
    logic            zero_s;
    logic            dn_acc_s;
    logic            get_s;
    logic            put_s;
    logic            push_s;
    logic            pop_s;
    logic            done_set_s;
    logic [CW-1:0]   len_last_s;

    // dn_start wins over up_start; starts outside IDLE are dropped
    assign start_s    = (state_r == ST_IDLE) && (dn_start || up_start);
    assign bad_s      = (dfu_block >= MAX_PAGES) || (dfu_length > PAGE_SIZE_W);
    assign zero_s     = (dfu_length == 16'd0);
    assign len_last_s = len_r - CNT_ONE;
    assign dn_acc_s   = (state_r == ST_DN_FILL) && dn_valid;
    assign get_s      = (state_r == ST_DN_STREAM) && flash_wr_data_get && (rptr_r < len_r);
    assign put_s      = (state_r == ST_UP_STREAM) && flash_rd_data_put && (rptr_r < len_r);
    assign pop_s      = (fifo_cnt_r != 3'd0) && up_ready;
    assign push_s     = put_s && ((fifo_cnt_r != 3'd4) || pop_s);

    // Outputs decoded from registered state only
    assign busy                = (state_r != ST_IDLE);
    assign dn_ready            = (state_r == ST_DN_FILL);
    assign flash_wr_request    = (state_r == ST_DN_REQ) || (state_r == ST_DN_STREAM);
    assign flash_wr_data_avail = (state_r == ST_DN_STREAM) && (rptr_r < len_r);
    assign flash_rd_request    = (state_r == ST_UP_STREAM);
    assign flash_rd_data_free  = (state_r == ST_UP_STREAM) && (fifo_cnt_r <= 3'd2);
    assign up_valid            = (fifo_cnt_r != 3'd0);
    assign up_data             = fifo_mem_r[fifo_rp_r];
    assign done                = done_r;
    assign error               = error_r;
    assign flash_address       = addr_r;
    assign flash_wr_data       = wr_data_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and done request
    always_comb begin
        state_nx_s = state_r;
        done_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (bad_s || zero_s) begin
                        done_set_s = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else if (dn_start) begin
                        state_nx_s = ST_DN_FILL;
                    end else begin
                        state_nx_s = ST_UP_STREAM;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DN_FILL: begin
                if (dn_acc_s && (wptr_r == len_last_s)) begin
                    state_nx_s = ST_DN_REQ;
                end else begin
                    state_nx_s = ST_DN_FILL;
                end
            end
            ST_DN_REQ: begin
                // avail stays low until the bridge has left its idle state
                if (flash_wr_busy) begin
                    state_nx_s = ST_DN_STREAM;
                end else begin
                    state_nx_s = ST_DN_REQ;
                end
            end
            ST_DN_STREAM: begin
                if (get_s && (rptr_r == len_last_s)) begin
                    state_nx_s = ST_DN_WAIT;
                end else begin
                    state_nx_s = ST_DN_STREAM;
                end
            end
            ST_DN_WAIT: begin
                if (!flash_wr_busy) begin
                    done_set_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DN_WAIT;
                end
            end
            ST_UP_STREAM: begin
                if (put_s && (rptr_r == len_last_s)) begin
                    state_nx_s = ST_UP_DRAIN;
                end else begin
                    state_nx_s = ST_UP_STREAM;
                end
            end
            ST_UP_DRAIN: begin
                if (fifo_cnt_r == 3'd0) begin
                    done_set_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_UP_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Transaction registers: address/length latch, pointers, status, write byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r    <= 16'h0000;
            len_r     <= CNT_ZERO;
            wptr_r    <= CNT_ZERO;
            rptr_r    <= CNT_ZERO;
            error_r   <= 1'b0;
            done_r    <= 1'b0;
            wr_data_r <= 8'h00;
        end else begin
            done_r <= done_set_s;
            if (start_s) begin
                addr_r  <= BASE_PAGE + dfu_block;
                len_r   <= dfu_length[CW-1:0];
                error_r <= bad_s;
                wptr_r  <= CNT_ZERO;
                rptr_r  <= CNT_ZERO;
            end else begin
                if (dn_acc_s) begin
                    wptr_r <= wptr_r + CNT_ONE;
                end
                if (get_s || put_s) begin
                    rptr_r <= rptr_r + CNT_ONE;
                end
            end
            // bridge samples the byte one cycle after its get strobe
            if (get_s) begin
                wr_data_r <= buf_mem_r[rptr_r[AW-1:0]];
            end
        end
    end

    // Page buffer write port (storage only, no reset needed)
    always_ff @(posedge clk) begin
        if (dn_acc_s) begin
            buf_mem_r[wptr_r[AW-1:0]] <= dn_data;
        end
    end

    // Upload FIFO; free falls at 3 entries so one in-flight byte still fits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem_r <= '{default: 8'h00};
            fifo_wp_r  <= 2'd0;
            fifo_rp_r  <= 2'd0;
            fifo_cnt_r <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[fifo_wp_r] <= flash_rd_data;
                fifo_wp_r             <= fifo_wp_r + 2'd1;
            end
            if (pop_s) begin
                fifo_rp_r <= fifo_rp_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 3'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 3'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_dfu_flash_sequencer.sv
// Directed bench for dfu_flash_sequencer with simple write/read bridge models.
module tb_dfu_flash_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dn_start = 1'b0;
    logic        up_start = 1'b0;
    logic [15:0] dfu_block = 16'h0000;
    logic [15:0] dfu_length = 16'h0000;
    logic        dn_valid = 1'b0;
    logic        dn_ready;
    logic [7:0]  dn_data = 8'h00;
    logic        up_valid;
    logic        up_ready = 1'b0;
    logic [7:0]  up_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] flash_address;
    logic        flash_rd_request;
    logic        flash_rd_data_free;
    logic        flash_rd_data_put = 1'b0;
    logic [7:0]  flash_rd_data = 8'h00;
    logic        flash_wr_request;
    logic        flash_wr_data_avail;
    logic        flash_wr_busy = 1'b0;
    logic        flash_wr_data_get = 1'b0;
    logic [7:0]  flash_wr_data;

    int vec_cnt = 0;
    int miscompare_cnt = 0;
    logic [7:0] exp_bytes [256];

    int   r_gets, r_bad, r_dones, r_early, r_busy_low, r_avail_early, r_req_early;
    int   r_rx, r_extras, r_max_occ;
    logic r_req_last;

    dfu_flash_sequencer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .dn_start            (dn_start),
        .up_start            (up_start),
        .dfu_block           (dfu_block),
        .dfu_length          (dfu_length),
        .dn_valid            (dn_valid),
        .dn_ready            (dn_ready),
        .dn_data             (dn_data),
        .up_valid            (up_valid),
        .up_ready            (up_ready),
        .up_data             (up_data),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .flash_address       (flash_address),
        .flash_rd_request    (flash_rd_request),
        .flash_rd_data_free  (flash_rd_data_free),
        .flash_rd_data_put   (flash_rd_data_put),
        .flash_rd_data       (flash_rd_data),
        .flash_wr_request    (flash_wr_request),
        .flash_wr_data_avail (flash_wr_data_avail),
        .flash_wr_busy       (flash_wr_busy),
        .flash_wr_data_get   (flash_wr_data_get),
        .flash_wr_data       (flash_wr_data)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs_vec();
        return {23'd0, busy, done, error, dn_ready, up_valid, flash_rd_request,
                flash_rd_data_free, flash_wr_request, flash_wr_data_avail,
                flash_address, flash_wr_data, up_data};
    endfunction

    task automatic start_txn(input logic dn, input logic up, input logic [15:0] blk, input logic [15:0] len);
        dn_start   = dn;
        up_start   = up;
        dfu_block  = blk;
        dfu_length = len;
        tick();
        dn_start = 1'b0;
        up_start = 1'b0;
    endtask

    task automatic fill(input int n, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            dn_valid = 1'b1;
            dn_data  = exp_bytes[i];
            if (dn_ready) acc++;
            tick();
        end
        dn_valid = 1'b0;
    endtask

    // Count cycles in which any flash request or busy shows up
    task automatic watch_idle(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (flash_wr_request || flash_rd_request || busy) seen++;
            tick();
        end
    endtask

    // Write-side bridge: busy rises lat cycles after request, get every gap
    // cycles while avail, busy held hold cycles after request falls.
    task automatic run_wr_bridge(input int lat, input int gap, input int hold, input int nbytes);
        int   req_cyc = 0;
        int   gap_cnt = 0;
        int   hold_cnt = 0;
        int   post = 0;
        logic busy_fell = 1'b0;
        logic sample_pend = 1'b0;
        logic last_pend = 1'b0;
        r_gets = 0; r_bad = 0; r_dones = 0; r_early = 0; r_busy_low = 0;
        r_avail_early = 0; r_req_early = 0; r_req_last = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (sample_pend) begin
                if (flash_wr_data !== exp_bytes[r_gets-1]) r_bad++;
                sample_pend = 1'b0;
            end
            if (last_pend) begin
                r_req_last = flash_wr_request;
                last_pend  = 1'b0;
            end
            if (done) begin
                r_dones++;
                if (!busy_fell) r_early++;
            end
            if (r_dones == 0 && !done && !busy) r_busy_low++;
            if (flash_wr_data_avail && !flash_wr_busy) r_avail_early++;
            flash_wr_data_get = 1'b0;
            if (r_dones != 0) begin
                post++;
                if (post > 3) break;
            end
            if (!flash_wr_busy) begin
                if (!busy_fell && flash_wr_request) begin
                    req_cyc++;
                    if (req_cyc >= lat) flash_wr_busy = 1'b1;
                end
            end else if (!flash_wr_request) begin
                if (r_gets < nbytes) r_req_early++;
                hold_cnt++;
                if (hold_cnt > hold) begin
                    flash_wr_busy = 1'b0;
                    busy_fell     = 1'b1;
                end
            end else if (flash_wr_data_avail) begin
                gap_cnt++;
                if (gap_cnt >= gap) begin
                    flash_wr_data_get = 1'b1;
                    gap_cnt = 0;
                    r_gets++;
                    sample_pend = 1'b1;
                    if (r_gets == nbytes) last_pend = 1'b1;
                end
            end
            tick();
        end
        flash_wr_data_get = 1'b0;
        flash_wr_busy     = 1'b0;
    endtask

    // Read-side bridge: puts byte index every 16 cycles while free, then three
    // stray puts of 0xEE after the request falls; consumer ready 64 on / 64 off.
    task automatic run_rd_bridge();
        int   gap_cnt = 0;
        int   puts = 0;
        int   pops = 0;
        int   post = 0;
        logic req_fell = 1'b0;
        r_rx = 0; r_bad = 0; r_dones = 0; r_extras = 0; r_max_occ = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (done) r_dones++;
            if (r_dones != 0 && r_extras >= 3) begin
                post++;
                if (post > 3) break;
            end
            up_ready = ((cyc / 64) % 2) == 1;
            if (up_valid && up_ready) begin
                if (up_data !== 8'(r_rx)) r_bad++;
                r_rx++;
                pops++;
            end
            if (!flash_rd_request && puts > 0) req_fell = 1'b1;
            flash_rd_data_put = 1'b0;
            gap_cnt++;
            if (gap_cnt >= 16) begin
                if (flash_rd_request && flash_rd_data_free) begin
                    flash_rd_data_put = 1'b1;
                    flash_rd_data     = 8'(puts);
                    puts++;
                    gap_cnt = 0;
                end else if (req_fell && r_extras < 3) begin
                    flash_rd_data_put = 1'b1;
                    flash_rd_data     = 8'hEE;
                    r_extras++;
                    gap_cnt = 0;
                end
            end
            if (puts - pops > r_max_occ) r_max_occ = puts - pops;
            tick();
        end
        flash_rd_data_put = 1'b0;
        up_ready          = 1'b0;
    endtask

    initial begin
        int acc;
        int seen;

        // Reset values
        tick(); tick();
        check_val("reset_outs_in_reset", outs_vec(), 64'd0);
        reset_n = 1'b1;
        tick();
        check_val("reset_outs_after", outs_vec(), 64'd0);

        // DNLOAD block 3, 256 bytes 0x00..0xFF
        for (int i = 0; i < 256; i++) exp_bytes[i] = 8'(i);
        start_txn(1'b1, 1'b0, 16'h0003, 16'd256);
        check_val("dn256_busy", 64'(busy), 64'd1);
        check_val("dn256_addr", 64'(flash_address), 64'h0003);
        check_val("dn256_ready", 64'(dn_ready), 64'd1);
        fill(256, acc);
        check_val("dn256_accepted", 64'(acc), 64'd256);
        check_val("dn256_req_state", {61'd0, dn_ready, flash_wr_request, flash_wr_data_avail}, 64'b010);
        run_wr_bridge(2, 18, 0, 256);
        check_val("dn256_gets", 64'(r_gets), 64'd256);
        check_val("dn256_data_bad", 64'(r_bad), 64'd0);
        check_val("dn256_req_after_last", 64'(r_req_last), 64'd0);
        check_val("dn256_req_early", 64'(r_req_early), 64'd0);
        check_val("dn256_avail_early", 64'(r_avail_early), 64'd0);
        check_val("dn256_dones", 64'(r_dones), 64'd1);
        check_val("dn256_done_early", 64'(r_early), 64'd0);
        check_val("dn256_busy_low", 64'(r_busy_low), 64'd0);
        check_val("dn256_idle", 64'(busy), 64'd0);

        // Rejection: block == MAX_PAGES
        start_txn(1'b1, 1'b0, 16'h0400, 16'd4);
        check_val("rej_blk_flags", {61'd0, busy, done, error}, 64'b011);
        tick();
        check_val("rej_blk_done_once", {62'd0, done, error}, 64'b01);
        watch_idle(4, seen);
        check_val("rej_blk_no_req", 64'(seen), 64'd0);

        // Rejection: length 257
        start_txn(1'b0, 1'b1, 16'h0001, 16'd257);
        check_val("rej_len_flags", {61'd0, busy, done, error}, 64'b011);
        watch_idle(4, seen);
        check_val("rej_len_no_req", 64'(seen), 64'd0);

        // Manifest (DNLOAD length 0) clears error and pulses done
        start_txn(1'b1, 1'b0, 16'h0001, 16'd0);
        check_val("manifest_flags", {61'd0, busy, done, error}, 64'b010);
        watch_idle(4, seen);
        check_val("manifest_no_req", 64'(seen), 64'd0);
        start_txn(1'b0, 1'b1, 16'h0002, 16'd0);
        check_val("up_len0_flags", {60'd0, busy, done, error, flash_rd_request}, 64'b0100);

        // Simultaneous starts, then a stray dn_start mid-write, long busy hold
        for (int i = 0; i < 5; i++) exp_bytes[i] = 8'h3C + 8'(i * 17);
        start_txn(1'b1, 1'b1, 16'h0005, 16'd5);
        check_val("both_start_dn_wins", {62'd0, dn_ready, flash_rd_request}, 64'b10);
        check_val("both_start_addr", 64'(flash_address), 64'h0005);
        fill(5, acc);
        check_val("dn5_accepted", 64'(acc), 64'd5);
        start_txn(1'b1, 1'b0, 16'h0007, 16'd9);
        check_val("second_start_addr", 64'(flash_address), 64'h0005);
        check_val("second_start_state", {62'd0, flash_wr_request, dn_ready}, 64'b10);
        run_wr_bridge(2, 3, 1000, 5);
        check_val("dn5_gets", 64'(r_gets), 64'd5);
        check_val("dn5_data_bad", 64'(r_bad), 64'd0);
        check_val("dn5_req_after_last", 64'(r_req_last), 64'd0);
        check_val("dn5_dones", 64'(r_dones), 64'd1);
        check_val("dn5_done_early", 64'(r_early), 64'd0);
        check_val("dn5_busy_low", 64'(r_busy_low), 64'd0);

        // UPLOAD block 0x10, 64 bytes
        start_txn(1'b0, 1'b1, 16'h0010, 16'd64);
        check_val("up_start_state", {62'd0, busy, flash_rd_request}, 64'b11);
        check_val("up_addr", 64'(flash_address), 64'h0010);
        run_rd_bridge();
        check_val("up_rx_count", 64'(r_rx), 64'd64);
        check_val("up_data_bad", 64'(r_bad), 64'd0);
        check_val("up_extras_sent", 64'(r_extras), 64'd3);
        check_val("up_occ_le4", 64'(r_max_occ <= 4), 64'd1);
        check_val("up_dones", 64'(r_dones), 64'd1);
        check_val("up_end_state", {61'd0, busy, up_valid, flash_rd_request}, 64'b000);

        // Asynchronous reset in the middle of DN_STREAM
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h5A; exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'h3C;
        start_txn(1'b1, 1'b0, 16'h0009, 16'd4);
        fill(4, acc);
        flash_wr_busy = 1'b1;
        for (int i = 0; i < 10 && !flash_wr_data_avail; i++) tick();
        flash_wr_data_get = 1'b1;
        tick();
        flash_wr_data_get = 1'b0;
        check_val("rst_pre_data", 64'(flash_wr_data), 64'hA5);
        check_val("rst_pre_busy", {62'd0, busy, flash_wr_request}, 64'b11);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_outs", outs_vec(), 64'd0);
        flash_wr_busy = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        check_val("rst_release_outs", outs_vec(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
